// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator and its BTB.
package pc_pkg;

    // Fetch sequencer states: BOOT is the single bubble after reset,
    // ERR parks the front end after a misaligned redirect until a trap.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } pc_state_e;

    // Low address bits that must be zero for a 4-byte aligned target.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Default sequential fetch increment in bytes.
    localparam int STEP_BYTES = 4;

    // Widest address the BTB entry fields are sized for.
    localparam int BTB_XLEN_MAX = 32;

    // One BTB line: the tag holds the PC bits above the index, zero-extended.
    typedef struct packed {
        logic                    valid;
        logic [BTB_XLEN_MAX-1:0] tag;
        logic [BTB_XLEN_MAX-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// clocked install/invalidate from EX. A same-cycle lookup sees the old entry.
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int IW = $clog2(BTB_DEPTH);

    btb_entry_t              mem [BTB_DEPTH];
    logic [IW-1:0]           lk_idx;
    logic [IW-1:0]           up_idx;
    logic [BTB_XLEN_MAX-1:0] lk_tag;
    logic [BTB_XLEN_MAX-1:0] up_tag;
    logic                    lk_aligned;
    logic                    up_aligned;
    btb_entry_t              lk_entry;

    assign lk_idx     = lookup_pc[IW+1:2];
    assign up_idx     = upd_pc[IW+1:2];
    assign lk_tag     = BTB_XLEN_MAX'(lookup_pc[XLEN-1:IW+2]);
    assign up_tag     = BTB_XLEN_MAX'(upd_pc[XLEN-1:IW+2]);
    // A misaligned PC can never be a branch, so it neither hits nor installs.
    assign lk_aligned = ((lookup_pc[1:0] & ALIGN_MASK) == 2'b00);
    assign up_aligned = ((upd_pc[1:0] & ALIGN_MASK) == 2'b00);

    // Lookup: hit when the indexed line is valid and the tag matches.
    always_comb begin
        lk_entry    = mem[lk_idx];
        hit         = lk_entry.valid && (lk_entry.tag == lk_tag) && lk_aligned;
        pred_target = lk_entry.target[XLEN-1:0];
    end

    // Update: only valid bits are reset; tag/target are don't-care until installed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (upd_valid && up_aligned) begin
            mem[up_idx].valid <= upd_taken;
            if (upd_taken) begin
                mem[up_idx].tag    <= up_tag;
                mem[up_idx].target <= BTB_XLEN_MAX'(upd_target);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the RV32 front end: fetch handshake, trap and
// redirect priority, stall handling and misaligned-target detection.
// Optional BTB prediction is built when the macro PC_BTB_EN is defined.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = STEP_BYTES,
    parameter int              BTB_DEPTH    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_out,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    output logic            flush,
    output logic            misalign_err,
    output logic [XLEN-1:0] err_addr,
    output logic            pred_taken,
    input  logic            btb_upd_valid,
    input  logic [XLEN-1:0] btb_upd_pc,
    input  logic [XLEN-1:0] btb_upd_target,
    input  logic            btb_upd_taken
);

    pc_state_e       state, state_n;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] err_addr_n;
    logic            flush_n;
    logic            fire;
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;

`ifdef PC_BTB_EN
    pc_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_out),
        .hit         (btb_hit),
        .pred_target (btb_target),
        .upd_valid   (btb_upd_valid),
        .upd_pc      (btb_upd_pc),
        .upd_target  (btb_upd_target),
        .upd_taken   (btb_upd_taken)
    );
`else
    logic unused_btb;
    assign unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken};
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
`endif

    assign fetch_valid  = (state == RUN);
    assign misalign_err = (state == ERR);
    assign pred_taken   = btb_hit;
    assign fire         = fetch_valid & fetch_ready & en;

    // Next-PC mux and state transitions, trap over redirect over fire.
    always_comb begin
        state_n    = state;
        pc_n       = pc_out;
        err_addr_n = err_addr;
        flush_n    = 1'b0;
        case (state)
            BOOT: begin
                // Trap and redirect are dropped here: one bubble, then fetch.
                state_n = RUN;
            end
            RUN, ERR: begin
                if (trap_valid) begin
                    pc_n    = trap_pc;
                    flush_n = 1'b1;
                    state_n = RUN;
                end else if (redirect_valid && (state == RUN)) begin
                    flush_n = 1'b1;
                    if ((redirect_pc[1:0] & ALIGN_MASK) != 2'b00) begin
                        err_addr_n = redirect_pc;
                        state_n    = ERR;
                    end else begin
                        pc_n = redirect_pc;
                    end
                end else if (fire) begin
                    pc_n = btb_hit ? btb_target : (pc_out + XLEN'(STEP));
                end
            end
            default: state_n = BOOT;
        endcase
    end

    // State, PC, error capture and the one-cycle flush pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            pc_out   <= RESET_VECTOR;
            err_addr <= '0;
            flush    <= 1'b0;
        end else begin
            state    <= state_n;
            pc_out   <= pc_n;
            err_addr <= err_addr_n;
            flush    <= flush_n;
        end
    end

endmodule
